// File: rtl/fetch_unit.sv
// Instruction fetch stage: keeps one i_cache read outstanding and buffers the
// returned {pc, instr} pairs in a circular queue toward decode. Redirects flush.
module fetch_unit #(
    parameter int               WIDTH    = 64,
    parameter int               INSTSIZE = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    parameter int               QDEPTH   = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                redirect_valid,
    input  logic [WIDTH-1:0]    redirect_pc,
    output logic [WIDTH-1:0]    ic_pc,
    output logic                ic_req,
    input  logic [INSTSIZE-1:0] ic_instr,
    input  logic                ic_rdy,
    output logic                dec_valid,
    output logic [WIDTH-1:0]    dec_pc,
    output logic [INSTSIZE-1:0] dec_instr,
    input  logic                dec_ready
);

    localparam int PTRW = $clog2(QDEPTH);
    localparam int CW   = PTRW + 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DRAIN
    } state_e;

    state_e              state_q, state_d;
    logic [WIDTH-1:0]    fetchPc_q, fetchPc_d;
    logic [WIDTH-1:0]    icPc_q, icPc_d;
    logic [PTRW-1:0]     rdPtr_q, rdPtr_d;
    logic [PTRW-1:0]     wrPtr_q, wrPtr_d;
    logic [CW-1:0]       count_q, count_d;
    logic [CW-1:0]       countAfter;
    logic [WIDTH-1:0]    redirPc;
    logic [WIDTH-1:0]    pcPlus4;
    logic                push;
    logic                pop;
    logic                headValid;

    logic [WIDTH-1:0]    pcMem    [QDEPTH];
    logic [INSTSIZE-1:0] instrMem [QDEPTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            fetchPc_q <= RESET_PC;
            icPc_q    <= RESET_PC;
            rdPtr_q   <= '0;
            wrPtr_q   <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            fetchPc_q <= fetchPc_d;
            icPc_q    <= icPc_d;
            rdPtr_q   <= rdPtr_d;
            wrPtr_q   <= wrPtr_d;
            count_q   <= count_d;
        end
    end

    // Queue storage needs no reset: dec_* are masked to zero while empty.
    always_ff @(posedge clk) begin
        if (push) begin
            pcMem[wrPtr_q]    <= icPc_q;
            instrMem[wrPtr_q] <= ic_instr;
        end
    end

    always_comb begin
        headValid  = (count_q != '0);
        pop        = headValid && dec_ready;
        push       = (state_q == WAIT) && ic_rdy && !redirect_valid;
        countAfter = count_q + CW'(push) - CW'(pop);
        redirPc    = redirect_pc & ~WIDTH'(3);
        pcPlus4    = fetchPc_q + WIDTH'(4);

        state_d   = state_q;
        fetchPc_d = fetchPc_q;
        icPc_d    = icPc_q;

        unique case (state_q)
            IDLE: begin
                if (redirect_valid) begin
                    fetchPc_d = redirPc;
                    icPc_d    = redirPc;
                end else if (count_q < CW'(QDEPTH)) begin
                    icPc_d  = fetchPc_q;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (redirect_valid) begin
                    fetchPc_d = redirPc;
                    if (ic_rdy) begin
                        icPc_d  = redirPc;
                        state_d = IDLE;
                    end else begin
                        // The in-flight request cannot be withdrawn, so ic_pc stays put.
                        state_d = DRAIN;
                    end
                end else if (ic_rdy) begin
                    fetchPc_d = pcPlus4;
                    if (countAfter < CW'(QDEPTH)) begin
                        icPc_d = pcPlus4;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DRAIN: begin
                if (redirect_valid) begin
                    fetchPc_d = redirPc;
                end
                if (ic_rdy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rdPtr_d = rdPtr_q;
        wrPtr_d = wrPtr_q;
        count_d = count_q;
        if (redirect_valid) begin
            rdPtr_d = '0;
            wrPtr_d = '0;
            count_d = '0;
        end else begin
            if (push) begin
                wrPtr_d = wrPtr_q + PTRW'(1);
            end
            if (pop) begin
                rdPtr_d = rdPtr_q + PTRW'(1);
            end
            count_d = countAfter;
        end
    end

    always_comb begin
        ic_req    = (state_q != IDLE);
        ic_pc     = icPc_q;
        dec_valid = headValid;
        dec_pc    = headValid ? pcMem[rdPtr_q] : '0;
        dec_instr = headValid ? instrMem[rdPtr_q] : '0;
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming fetch, backpressure, redirects,
// DRAIN handling, queue wrap, PC wrap and asynchronous reset.
module tb_fetch_unit;

    localparam int          WIDTH    = 64;
    localparam int          INSTSIZE = 32;
    localparam int          QDEPTH   = 4;
    localparam logic [63:0] RESET_PC = 64'h1000;
    localparam int          RDLAT    = 2;

    logic                clk = 1'b0;
    logic                reset;
    logic                redirect_valid;
    logic [WIDTH-1:0]    redirect_pc;
    logic [WIDTH-1:0]    ic_pc;
    logic                ic_req;
    logic [INSTSIZE-1:0] ic_instr;
    logic                ic_rdy;
    logic                dec_valid;
    logic [WIDTH-1:0]    dec_pc;
    logic [INSTSIZE-1:0] dec_instr;
    logic                dec_ready;

    int   checks    = 0;
    int   failures  = 0;
    logic autoResp  = 1'b0;
    int   age       = 0;
    int   respCount = 0;

    fetch_unit #(
        .WIDTH   (WIDTH),
        .INSTSIZE(INSTSIZE),
        .RESET_PC(RESET_PC),
        .QDEPTH  (QDEPTH)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .ic_pc         (ic_pc),
        .ic_req        (ic_req),
        .ic_instr      (ic_instr),
        .ic_rdy        (ic_rdy),
        .dec_valid     (dec_valid),
        .dec_pc        (dec_pc),
        .dec_instr     (dec_instr),
        .dec_ready     (dec_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] instrOf(input logic [63:0] pc);
        return pc[31:0] ^ 32'hC0DE_0000;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic rv, input logic [63:0] rpc, input logic rdy,
                                 input logic [31:0] ins, input logic decRdy);
        redirect_valid = rv;
        redirect_pc    = rpc;
        ic_rdy         = rdy;
        ic_instr       = ins;
        dec_ready      = decRdy;
        tick();
    endtask

    task automatic doReset();
        autoResp       = 1'b0;
        ic_rdy         = 1'b0;
        ic_instr       = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        dec_ready      = 1'b0;
        reset          = 1'b0;
        tick();
        tick();
    endtask

    // Cache model: answers each request RDLAT sampled cycles after it appears.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!autoResp) begin
                age = 0;
            end else if (ic_rdy) begin
                ic_rdy = 1'b0;
                age    = 0;
            end else if (ic_req) begin
                age++;
                if (age == RDLAT) begin
                    ic_rdy   = 1'b1;
                    ic_instr = instrOf(ic_pc);
                    respCount++;
                end
            end else begin
                age = 0;
            end
        end
    end

    initial begin
        logic [63:0] t1Pc    [3];
        logic [31:0] t1Instr [3];
        int          got;
        int          dropped;
        logic        seenReq;

        t1Pc    = '{64'h1000, 64'h1004, 64'h1008};
        t1Instr = '{32'hC0DE_1000, 32'hC0DE_1004, 32'hC0DE_1008};

        doReset();
        $display("[TB] reset state");
        checkOutput("rst ic_req", ic_req, 0);
        checkOutput("rst ic_pc", ic_pc, 64'h1000);
        checkOutput("rst dec_valid", dec_valid, 0);
        checkOutput("rst dec_pc", dec_pc, 0);
        checkOutput("rst dec_instr", dec_instr, 0);

        $display("[TB] test 1: streaming fetch");
        dec_ready = 1'b1;
        autoResp  = 1'b1;
        reset     = 1'b1;
        got       = 0;
        dropped   = 0;
        seenReq   = 1'b0;
        for (int c = 0; c < 60 && got < 3; c++) begin
            tick();
            if (ic_req) seenReq = 1'b1;
            else if (seenReq) dropped++;
            if (dec_valid && dec_ready) begin
                checkOutput("t1 dec_pc", dec_pc, t1Pc[got]);
                checkOutput("t1 dec_instr", dec_instr, 64'(t1Instr[got]));
                got++;
            end
        end
        checkOutput("t1 entries", 64'(got), 3);
        checkOutput("t1 ic_req gaps", 64'(dropped), 0);

        $display("[TB] test 2: backpressure fills queue");
        doReset();
        respCount = 0;
        autoResp  = 1'b1;
        reset     = 1'b1;
        for (int c = 0; c < 60; c++) tick();
        checkOutput("t2 pushes", 64'(respCount), 4);
        checkOutput("t2 ic_req idle", ic_req, 0);
        checkOutput("t2 dec_valid", dec_valid, 1);
        checkOutput("t2 head", dec_pc, 64'h1000);
        dec_ready = 1'b1;
        tick();
        dec_ready = 1'b0;
        checkOutput("t2 head after pop", dec_pc, 64'h1004);
        checkOutput("t2 req after pop", ic_req, 0);
        tick();
        checkOutput("t2 new req", ic_req, 1);
        checkOutput("t2 new ic_pc", ic_pc, 64'h1010);
        for (int c = 0; c < 20; c++) tick();
        checkOutput("t2 one more push", 64'(respCount), 5);
        checkOutput("t2 idle again", ic_req, 0);
        autoResp  = 1'b0;
        dec_ready = 1'b1;
        checkOutput("t2 pop0", dec_pc, 64'h1004);
        tick();
        checkOutput("t2 pop1", dec_pc, 64'h1008);
        tick();
        checkOutput("t2 pop2", dec_pc, 64'h100C);
        tick();
        checkOutput("t2 pop3", dec_pc, 64'h1010);
        checkOutput("t2 pop3 instr", dec_instr, 32'hC0DE_1010);
        tick();
        checkOutput("t2 drained", dec_valid, 0);

        $display("[TB] test 3: redirect while waiting");
        doReset();
        reset = 1'b1;
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("t3 req", ic_req, 1);
        checkOutput("t3 ic_pc", ic_pc, 64'h1000);
        applyStimulus(0, 0, 1, 32'h1111_0000, 0);
        checkOutput("t3 pushed", dec_pc, 64'h1000);
        checkOutput("t3 pushed instr", dec_instr, 32'h1111_0000);
        checkOutput("t3 next ic_pc", ic_pc, 64'h1004);
        applyStimulus(1, 64'h2000, 0, 0, 0);
        checkOutput("t3 drain req", ic_req, 1);
        checkOutput("t3 drain ic_pc", ic_pc, 64'h1004);
        checkOutput("t3 flushed", dec_valid, 0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("t3 still drain", ic_req, 1);
        applyStimulus(0, 0, 1, 32'hBAD0_0000, 0);
        checkOutput("t3 drained idle", ic_req, 0);
        checkOutput("t3 stale dropped", dec_valid, 0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("t3 resume req", ic_req, 1);
        checkOutput("t3 resume ic_pc", ic_pc, 64'h2000);
        checkOutput("t3 still empty", dec_valid, 0);

        $display("[TB] test 4: redirect with response, double redirect in DRAIN");
        applyStimulus(1, 64'h3000, 1, 32'hBAD1_0000, 0);
        checkOutput("t4 idle", ic_req, 0);
        checkOutput("t4 ic_pc", ic_pc, 64'h3000);
        checkOutput("t4 dropped", dec_valid, 0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("t4 req", ic_req, 1);
        checkOutput("t4 req pc", ic_pc, 64'h3000);
        applyStimulus(1, 64'h4000, 0, 0, 0);
        checkOutput("t4 drain1", ic_pc, 64'h3000);
        applyStimulus(1, 64'h5000, 0, 0, 0);
        checkOutput("t4 drain2 req", ic_req, 1);
        checkOutput("t4 drain2 pc", ic_pc, 64'h3000);
        applyStimulus(0, 0, 1, 32'hBAD2_0000, 0);
        checkOutput("t4 drained", ic_req, 0);
        checkOutput("t4 empty", dec_valid, 0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("t4 resume pc", ic_pc, 64'h5000);
        checkOutput("t4 resume req", ic_req, 1);

        $display("[TB] test 5: push+pop at count 3, pointer wrap");
        applyStimulus(0, 0, 1, 32'hA000_0000, 0);
        applyStimulus(0, 0, 1, 32'hA000_0004, 0);
        applyStimulus(0, 0, 1, 32'hA000_0008, 0);
        checkOutput("t5 head", dec_pc, 64'h5000);
        checkOutput("t5 ic_pc", ic_pc, 64'h500C);
        applyStimulus(0, 0, 1, 32'hA000_000C, 1);
        checkOutput("t5 pp req", ic_req, 1);
        checkOutput("t5 pp ic_pc", ic_pc, 64'h5010);
        checkOutput("t5 pp head", dec_pc, 64'h5004);
        checkOutput("t5 pp instr", dec_instr, 32'hA000_0004);
        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("t5 pop a", dec_pc, 64'h5008);
        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("t5 pop b", dec_pc, 64'h500C);
        checkOutput("t5 pop b instr", dec_instr, 32'hA000_000C);
        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("t5 count was 3", dec_valid, 0);
        autoResp = 1'b1;
        got      = 0;
        for (int c = 0; c < 300 && got < 10; c++) begin
            dec_ready = (c % 3 != 1);
            if (dec_valid && dec_ready) begin
                checkOutput("t5 wrap pc", dec_pc, 64'h5010 + 64'(4 * got));
                checkOutput("t5 wrap instr", dec_instr, 64'(instrOf(64'h5010 + 64'(4 * got))));
                got++;
            end
            tick();
        end
        checkOutput("t5 wrap entries", 64'(got), 10);

        $display("[TB] test 6: PC wrap and async reset");
        doReset();
        reset = 1'b1;
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(1, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 0);
        checkOutput("t6 aligned pc", ic_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        checkOutput("t6 idle", ic_req, 0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("t6 req top", ic_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        applyStimulus(0, 0, 1, 32'h7777_0000, 0);
        checkOutput("t6 wrap ic_pc", ic_pc, 64'h0);
        checkOutput("t6 wrap req", ic_req, 1);
        checkOutput("t6 top entry", dec_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        ic_rdy = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        checkOutput("t6 async ic_req", ic_req, 0);
        checkOutput("t6 async ic_pc", ic_pc, 64'h1000);
        checkOutput("t6 async dec_valid", dec_valid, 0);
        checkOutput("t6 async dec_pc", dec_pc, 0);
        checkOutput("t6 async dec_instr", dec_instr, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
